// File: rtl/apb_slave_access_ctrl.sv
// APB transfer controller: takes one valid/ready request plus the decoder's one-hot
// select, runs SETUP/ACCESS on that slave and returns a single response pulse.
module apb_slave_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int NSLV    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [NSLV-1:0]      slave_sel,
    output logic [NSLV-1:0]      psel,
    output logic                 penable,
    output logic                 pwrite,
    output logic [31:0]          paddr,
    output logic [31:0]          pwdata,
    input  logic [NSLV-1:0]      pready,
    input  logic [NSLV-1:0]      pslverr,
    input  logic [32*NSLV-1:0]   prdata,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [NSLV-1:0] r_sel;
    logic [CW-1:0]   r_cnt;
    logic            w_accept;
    logic            w_selOk;
    logic            w_pready;
    logic            w_pslverr;
    logic            w_timeout;
    logic [31:0]     w_prdata;

    assign w_accept  = req_valid && (r_state == IDLE);
    assign w_selOk   = (slave_sel != '0) && ((slave_sel & (slave_sel - NSLV'(1))) == '0);
    assign w_pready  = |(pready & r_sel);
    assign w_pslverr = |(pslverr & r_sel);
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == LAST);

    // r_sel is one-hot whenever ACCESS is reached, so an OR of masked lanes is a mux
    always_comb begin
        w_prdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (r_sel[i]) w_prdata = w_prdata | prdata[32*i +: 32];
        end
    end

    assign req_ready = (r_state == IDLE);
    assign psel      = ((r_state == SETUP) || (r_state == ACCESS)) ? r_sel : '0;
    assign penable   = (r_state == ACCESS);
    assign rsp_valid = (r_state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = w_selOk ? SETUP : RESP;
            SETUP:   w_next = ACCESS;
            ACCESS:  if (w_pready || w_timeout) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // A bad select answers immediately with an error and never reaches the bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            paddr     <= '0;
            pwdata    <= '0;
            pwrite    <= 1'b0;
            r_sel     <= '0;
            r_cnt     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        paddr  <= req_addr;
                        pwdata <= req_wdata;
                        pwrite <= req_write;
                        r_sel  <= slave_sel;
                        if (!w_selOk) begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                SETUP: r_cnt <= '0;
                ACCESS: begin
                    if (w_pready) begin
                        rsp_err   <= w_pslverr;
                        rsp_rdata <= pwrite ? 32'd0 : w_prdata;
                    end else if (w_timeout) begin
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_access_ctrl.sv
// Directed bench for apb_slave_access_ctrl: expected responses are queued at request
// time and popped when rsp_valid fires.
module tb_apb_slave_access_ctrl;

    localparam int NSLV = 4;

    logic                clk;
    logic                rst_n;
    logic                req_valid;
    logic                req_ready;
    logic                req_write;
    logic [31:0]         req_addr;
    logic [31:0]         req_wdata;
    logic [NSLV-1:0]     slave_sel;
    logic [NSLV-1:0]     psel;
    logic                penable;
    logic                pwrite;
    logic [31:0]         paddr;
    logic [31:0]         pwdata;
    logic [NSLV-1:0]     pready;
    logic [NSLV-1:0]     pslverr;
    logic [32*NSLV-1:0]  prdata;
    logic                rsp_valid;
    logic [31:0]         rsp_rdata;
    logic                rsp_err;

    logic [32:0] sb[$];
    int passCount  = 0;
    int failCount  = 0;
    int totalCount = 0;

    apb_slave_access_ctrl #(.TIMEOUT(16), .NSLV(NSLV)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .slave_sel(slave_sel),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .pslverr(pslverr), .prdata(prdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Presents one request in IDLE, queues its expected response, and returns in the cycle after accept
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [NSLV-1:0] sel, input logic [31:0] expRdata,
                                 input logic expErr);
        checkOutput("reqReadyBeforeAccept", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        slave_sel = sel;
        sb.push_back({expErr, expRdata});
        step();
        req_valid = 1'b0;
    endtask

    task automatic expectResp(input string name, input int expWait);
        int n = 0;
        logic [32:0] e;
        while (rsp_valid !== 1'b1 && n < expWait + 20) begin
            step();
            n++;
        end
        checkOutput({name, "_latency"}, n, expWait);
        checkOutput({name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        checkOutput({name, "_sbNotEmpty"}, {31'd0, sb.size() > 0}, 32'd1);
        if (rsp_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput({name, "_rdata"}, rsp_rdata, e[31:0]);
            checkOutput({name, "_err"}, {31'd0, rsp_err}, {31'd0, e[32]});
        end
    endtask

    initial begin
        int acc;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        slave_sel = '0;
        pready    = '0;
        pslverr   = '0;
        prdata    = '0;

        step();
        checkOutput("rst_reqReady", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_psel", {28'd0, psel}, 32'd0);
        checkOutput("rst_penable", {31'd0, penable}, 32'd0);
        checkOutput("rst_rspValid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_paddr", paddr, 32'd0);
        checkOutput("rst_rdata", rsp_rdata, 32'd0);
        checkOutput("rst_err", {31'd0, rsp_err}, 32'd0);
        #5 rst_n = 1'b1;
        step();

        $display("[TB] test 1: zero-wait read");
        pready = 4'b0001;
        prdata[31:0] = 32'hDEADBEEF;
        applyStimulus(1'b0, 32'h0001_0000, 32'd0, 4'b0001, 32'hDEADBEEF, 1'b0);
        checkOutput("t1_setupPsel", {28'd0, psel}, 32'h1);
        checkOutput("t1_setupPenable", {31'd0, penable}, 32'd0);
        checkOutput("t1_setupReqReady", {31'd0, req_ready}, 32'd0);
        step();
        checkOutput("t1_accessPsel", {28'd0, psel}, 32'h1);
        checkOutput("t1_accessPenable", {31'd0, penable}, 32'd1);
        checkOutput("t1_paddr", paddr, 32'h0001_0000);
        expectResp("t1", 1);
        checkOutput("t1_respPsel", {28'd0, psel}, 32'd0);
        step();
        checkOutput("t1_pulseEnds", {31'd0, rsp_valid}, 32'd0);
        checkOutput("t1_rdataHold", rsp_rdata, 32'hDEADBEEF);
        checkOutput("t1_idleReady", {31'd0, req_ready}, 32'd1);

        $display("[TB] test 2: wait-state write");
        pready = 4'b0000;
        prdata[95:64] = 32'hFFFF_0000;
        applyStimulus(1'b1, 32'h0003_0004, 32'h1234_5678, 4'b0100, 32'd0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            checkOutput("t2_waitPenable", {31'd0, penable}, 32'd1);
            checkOutput("t2_waitPsel", {28'd0, psel}, 32'h4);
            checkOutput("t2_waitPaddr", paddr, 32'h0003_0004);
            checkOutput("t2_waitPwdata", pwdata, 32'h1234_5678);
            checkOutput("t2_waitPwrite", {31'd0, pwrite}, 32'd1);
            req_valid = (i == 0);
            req_addr  = 32'hBAD0_BAD0;
            req_wdata = 32'h0;
            slave_sel = 4'b0001;
            step();
        end
        req_valid = 1'b0;
        pready = 4'b0100;
        checkOutput("t2_lastPenable", {31'd0, penable}, 32'd1);
        checkOutput("t2_lastPaddr", paddr, 32'h0003_0004);
        expectResp("t2", 1);
        step();

        $display("[TB] test 3: decode faults");
        pready = 4'b1111;
        prdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0001};
        applyStimulus(1'b0, 32'h0000_0000, 32'd0, 4'b0000, 32'd0, 1'b1);
        checkOutput("t3a_psel", {28'd0, psel}, 32'd0);
        expectResp("t3a", 0);
        step();
        applyStimulus(1'b0, 32'h0000_0000, 32'd0, 4'b0011, 32'd0, 1'b1);
        checkOutput("t3b_psel", {28'd0, psel}, 32'd0);
        checkOutput("t3b_penable", {31'd0, penable}, 32'd0);
        expectResp("t3b", 0);
        step();

        $display("[TB] test 4: timeout");
        pready = 4'b0111;
        applyStimulus(1'b0, 32'h0004_0000, 32'd0, 4'b1000, 32'd0, 1'b1);
        step();
        acc = 0;
        while (penable === 1'b1 && acc < 40) begin
            acc++;
            step();
        end
        checkOutput("t4_accessCycles", acc, 32'd16);
        checkOutput("t4_pselDropped", {28'd0, psel}, 32'd0);
        expectResp("t4", 0);
        step();

        $display("[TB] test 5: slave error and unselected slaves ignored");
        pready  = 4'b0000;
        pslverr = 4'b0000;
        prdata  = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_F00D, 32'h0000_0001};
        applyStimulus(1'b0, 32'h0002_0000, 32'd0, 4'b0010, 32'hCAFE_F00D, 1'b1);
        step();
        pready  = 4'b1101;
        pslverr = 4'b0000;
        step();
        checkOutput("t5_stillAccess", {31'd0, penable}, 32'd1);
        pready  = 4'b0010;
        pslverr = 4'b0010;
        expectResp("t5a", 1);
        step();
        pready  = 4'b1111;
        pslverr = 4'b1101;
        prdata[63:32] = 32'h5A5A_A5A5;
        applyStimulus(1'b0, 32'h0002_0008, 32'd0, 4'b0010, 32'h5A5A_A5A5, 1'b0);
        expectResp("t5b", 2);
        step();

        $display("[TB] test 6: reset during ACCESS");
        pready  = 4'b0000;
        pslverr = 4'b0000;
        applyStimulus(1'b0, 32'h0004_0010, 32'd0, 4'b1000, 32'd0, 1'b1);
        step();
        step();
        step();
        checkOutput("t6_inAccess", {31'd0, penable}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        checkOutput("t6_rstPsel", {28'd0, psel}, 32'd0);
        checkOutput("t6_rstPenable", {31'd0, penable}, 32'd0);
        checkOutput("t6_rstRspValid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("t6_rstReqReady", {31'd0, req_ready}, 32'd1);
        step();
        checkOutput("t6_noRespDuringReset", {31'd0, rsp_valid}, 32'd0);
        #2 rst_n = 1'b1;
        step();
        checkOutput("t6_noRespAfterRelease", {31'd0, rsp_valid}, 32'd0);
        checkOutput("t6_readyAfterRelease", {31'd0, req_ready}, 32'd1);
        pready = 4'b0001;
        prdata[31:0] = 32'h0BAD_C0DE;
        applyStimulus(1'b0, 32'h0001_0020, 32'd0, 4'b0001, 32'h0BAD_C0DE, 1'b0);
        expectResp("t6", 2);
        step();

        checkOutput("sbDrained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
